debounce_bank: RTL and testbench

- Parametrised successor to the single-timer group debouncer: each of NIN push-button/switch inputs is debounced by its own settle timer.
- The settle period is set at run time.
- Per-channel rise/fall strobes are produced.
- A sticky event mask with a valid/ack handshake lets a bus peripheral or interrupt controller collect edges without losing any.

---
 rtl/debounce_bank_pkg.sv | 16 +
 rtl/debounce_chan.sv | 152 +++++++++++++++
 rtl/debounce_bank.sv | 102 ++++++++++
 tb/tb_debounce_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/debounce_bank_pkg.sv
// debounce_bank_pkg
// Shared definitions for the debounce bank: the per-channel state encoding
// and the depth of the input synchroniser.
package debounce_bank_pkg;

  // Per-channel debounce state. IDLE watches for a difference between the
  // synchronised input and the debounced level; SETTLE counts it out.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } chan_state_e;

  // Number of flip-flop stages between the raw pin and the debounce FSM.
  localparam int unsigned SYNC_STAGES = 2;

endpackage : debounce_bank_pkg

// File: rtl/debounce_chan.sv
// debounce_chan
// One debounced input channel: two-stage synchroniser, IDLE/SETTLE FSM with
// a run-time loaded settle counter, registered level and rise/fall strobes,
// and (when DEBOUNCE_BANK_HOLD_EN is defined) a saturating long-press counter.
//
// Ports:
//   i_clk    system clock
//   i_reset  synchronous active-high reset
//   i_in     raw asynchronous input bit
//   i_wait   settle count W, captured when the counter loads
//   o_level  debounced level
//   o_rise   one-cycle strobe coincident with a 0->1 level change
//   o_fall   one-cycle strobe coincident with a 1->0 level change
//   o_held   long-press level (0 unless DEBOUNCE_BANK_HOLD_EN)
//
// Configuration macro: DEBOUNCE_BANK_HOLD_EN enables the hold counter.
module debounce_chan
  import debounce_bank_pkg::*;
#(
  parameter int unsigned LGWAIT = 17
`ifdef DEBOUNCE_BANK_HOLD_EN
  ,
  parameter int unsigned LGHOLD = 24
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in,
  input  logic [LGWAIT-1:0] i_wait,
  output logic              o_level,
  output logic              o_rise,
  output logic              o_fall,
  output logic              o_held
);

  // sync_q[0] is the first stage (q_in), sync_q[SYNC_STAGES-1] is r_in.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   r_in_s;

  chan_state_e            state_q, state_d;
  logic [LGWAIT-1:0]      cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign r_in_s = sync_q[SYNC_STAGES-1];

  // Synchroniser shift register; plain flops with no logic between stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_in};
    end
  end

  // Debounce FSM next-state, counter and strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (r_in_s != level_q) begin
          cnt_d   = i_wait;
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (r_in_s == level_q) begin
          // Input went back before the count expired: treat as a glitch.
          state_d = ST_IDLE;
          cnt_d   = {LGWAIT{1'b0}};
        end else if (cnt_q == {LGWAIT{1'b0}}) begin
          level_d = r_in_s;
          rise_d  = r_in_s;
          fall_d  = ~r_in_s;
          state_d = ST_IDLE;
        end else begin
          // Decrement stops at zero, so the all-ones count cannot wrap.
          cnt_d = cnt_q - LGWAIT'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {LGWAIT{1'b0}};
      end
    endcase
  end

  // Debounce FSM state, counter, level and strobe registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {LGWAIT{1'b0}};
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

`ifdef DEBOUNCE_BANK_HOLD_EN
  logic [LGHOLD-1:0] hold_q, hold_d;
  logic              held_q, held_d;

  // Hold counter runs while the level is high and saturates at all-ones;
  // held uses the next level so it drops on the same edge as the fall.
  always_comb begin
    hold_d = {LGHOLD{1'b0}};
    if (level_q) begin
      if (hold_q == {LGHOLD{1'b1}}) begin
        hold_d = hold_q;
      end else begin
        hold_d = hold_q + LGHOLD'(1);
      end
    end else begin
      hold_d = {LGHOLD{1'b0}};
    end
    held_d = level_d & (hold_d == {LGHOLD{1'b1}});
  end

  // Hold counter and held-level registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hold_q <= {LGHOLD{1'b0}};
      held_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end

  assign o_held = held_q;
`else
  assign o_held = 1'b0;
`endif

endmodule : debounce_chan

// File: rtl/debounce_bank.sv
// debounce_bank
// NIN independently debounced inputs with per-channel rise/fall strobes and a
// sticky event mask that is collected with a valid (o_event) / ack handshake.
//
// Ports:
//   i_clk         system clock
//   i_reset       synchronous active-high reset
//   i_in          raw asynchronous inputs
//   i_wait        settle count W, sampled by each channel when it loads
//   o_debounced   debounced level per channel
//   o_rise        one-cycle 0->1 strobe per channel
//   o_fall        one-cycle 1->0 strobe per channel
//   o_event       high while o_event_mask is non-zero
//   o_event_mask  sticky record of edges since the last ack
//   i_ack         clears the mask; strobes in the same cycle still land
//   o_held        long-press level (0 unless DEBOUNCE_BANK_HOLD_EN)
//
// Configuration macro: DEBOUNCE_BANK_HOLD_EN adds a per-channel hold counter
// (threshold 2^LGHOLD-1 cycles) whose assertion also sets the event mask.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int unsigned NIN    = 8,
  parameter int unsigned LGWAIT = 17,
  parameter int unsigned LGHOLD = 24
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [NIN-1:0]    i_in,
  input  logic [LGWAIT-1:0] i_wait,
  output logic [NIN-1:0]    o_debounced,
  output logic [NIN-1:0]    o_rise,
  output logic [NIN-1:0]    o_fall,
  output logic              o_event,
  output logic [NIN-1:0]    o_event_mask,
  input  logic              i_ack,
  output logic [NIN-1:0]    o_held
);

  if ((NIN < 1) || (NIN > 32) || (LGWAIT < 1) || (LGHOLD < 1)) begin : g_param_check
    $error("debounce_bank: NIN must be 1..32, LGWAIT and LGHOLD at least 1");
  end

  for (genvar k = 0; k < NIN; k++) begin : g_chan
    debounce_chan #(
      .LGWAIT (LGWAIT)
`ifdef DEBOUNCE_BANK_HOLD_EN
      ,
      .LGHOLD (LGHOLD)
`endif
    ) u_chan (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_in    (i_in[k]),
      .i_wait  (i_wait),
      .o_level (o_debounced[k]),
      .o_rise  (o_rise[k]),
      .o_fall  (o_fall[k]),
      .o_held  (o_held[k])
    );
  end

  logic [NIN-1:0] mask_q, mask_d;
  logic           event_q;

`ifdef DEBOUNCE_BANK_HOLD_EN
  logic [NIN-1:0] held_prev_q;

  // Previous held level, used to turn a hold assertion into a one-shot event.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      held_prev_q <= {NIN{1'b0}};
    end else begin
      held_prev_q <= o_held;
    end
  end
`endif

  // Next mask: ack clears old bits first so a coincident strobe survives.
  always_comb begin
    mask_d = i_ack ? {NIN{1'b0}} : mask_q;
    mask_d = mask_d | o_rise | o_fall;
`ifdef DEBOUNCE_BANK_HOLD_EN
    mask_d = mask_d | (o_held & ~held_prev_q);
`endif
  end

  // Event mask and its registered OR, updated on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask_q  <= {NIN{1'b0}};
      event_q <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      event_q <= |mask_d;
    end
  end

  assign o_event_mask = mask_q;
  assign o_event      = event_q;

endmodule : debounce_bank

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;
  localparam int NIN    = 8;
  localparam int LGWAIT = 17;
  localparam int LGHOLD = 4;
  localparam int HMAX   = (1 << LGHOLD) - 1;
`ifdef DEBOUNCE_BANK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_reset;
  logic [NIN-1:0]    i_in;
  logic [LGWAIT-1:0] i_wait;
  logic              i_ack;
  logic [NIN-1:0]    o_debounced, o_rise, o_fall, o_event_mask, o_held;
  logic              o_event;

  always #5 clk = ~clk;

  debounce_bank #(.NIN(NIN), .LGWAIT(LGWAIT), .LGHOLD(LGHOLD)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_in         (i_in),
    .i_wait       (i_wait),
    .o_debounced  (o_debounced),
    .o_rise       (o_rise),
    .o_fall       (o_fall),
    .o_event      (o_event),
    .o_event_mask (o_event_mask),
    .i_ack        (i_ack),
    .o_held       (o_held)
  );

  typedef struct packed {
    logic [NIN-1:0] deb;
    logic [NIN-1:0] rise;
    logic [NIN-1:0] fall;
    logic [NIN-1:0] mask;
    logic [NIN-1:0] held;
    logic           ev;
  } snap_t;

  snap_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: raw input delayed two samples; a channel's level flips
  // once the delayed input has disagreed with it for W+2 consecutive samples,
  // W being the wait value seen on the first disagreeing sample.
  logic [NIN-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall, m_mask, m_held, m_hprev;
  logic           m_ev;
  int             m_run [NIN];
  int             m_wl  [NIN];
  int             m_hcnt[NIN];

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0;
    m_mask = '0; m_held = '0; m_hprev = '0; m_ev = 1'b0;
    for (int k = 0; k < NIN; k++) begin
      m_run[k] = 0; m_wl[k] = 0; m_hcnt[k] = 0;
    end
  endtask

  task automatic model_edge();
    logic [NIN-1:0] nr, nf, nl, nh;
    snap_t s;
    cyc++;
    if (i_reset) begin
      model_clear();
    end else begin
      nr = '0; nf = '0; nl = m_lvl; nh = '0;
      for (int k = 0; k < NIN; k++) begin
        if (m_s2[k] != m_lvl[k]) begin
          if (m_run[k] == 0) m_wl[k] = int'(i_wait);
          m_run[k]++;
          if (m_run[k] == m_wl[k] + 2) begin
            nl[k] = m_s2[k]; nr[k] = m_s2[k]; nf[k] = ~m_s2[k]; m_run[k] = 0;
          end
        end else begin
          m_run[k] = 0;
        end
        if (HOLD) begin
          if (!m_lvl[k]) m_hcnt[k] = 0;
          else if (m_hcnt[k] < HMAX) m_hcnt[k]++;
          nh[k] = nl[k] && (m_hcnt[k] == HMAX);
        end
      end
      m_mask  = (i_ack ? '0 : m_mask) | m_rise | m_fall | (m_held & ~m_hprev);
      m_ev    = |m_mask;
      m_hprev = m_held;
      m_rise = nr; m_fall = nf; m_lvl = nl; m_held = nh;
      m_s2 = m_s1; m_s1 = i_in;
    end
    s.deb = m_lvl; s.rise = m_rise; s.fall = m_fall;
    s.mask = m_mask; s.held = m_held; s.ev = m_ev;
    exp_q.push_back(s);
  endtask

  task automatic cycle(input logic [NIN-1:0] in, input int w, input logic ack, input logic rst);
    i_in = in; i_wait = LGWAIT'(w); i_ack = ack; i_reset = rst;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [NIN-1:0] got, input logic [NIN-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle; pop and compare.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      check("debounced", o_debounced, e.deb);
      check("rise", o_rise, e.rise);
      check("fall", o_fall, e.fall);
      check("event_mask", o_event_mask, e.mask);
      check("held", o_held, e.held);
      check("event", {{(NIN-1){1'b0}}, o_event}, {{(NIN-1){1'b0}}, e.ev});
    end
  end

  initial begin
    logic [NIN-1:0] in_v;
    int w_cur;
    int rate;
    model_clear();
    i_reset = 1'b1; i_in = '0; i_wait = '0; i_ack = 1'b0;

    // Input high through reset, W=3: rise 7 edges after reset release.
    repeat (3) cycle(8'h01, 3, 1'b0, 1'b1);
    repeat (12) cycle(8'h01, 3, 1'b0, 1'b0);

    // Glitch shorter than the settle time on ch2.
    repeat (2) cycle(8'h00, 10, 1'b0, 1'b1);
    repeat (5) cycle(8'h04, 10, 1'b0, 1'b0);
    repeat (25) cycle(8'h00, 10, 1'b0, 1'b0);

    // Two channels stepped 2 cycles apart, then ack.
    cycle(8'h02, 4, 1'b0, 1'b0);
    cycle(8'h02, 4, 1'b0, 1'b0);
    repeat (12) cycle(8'h22, 4, 1'b0, 1'b0);
    cycle(8'h22, 4, 1'b1, 1'b0);
    repeat (3) cycle(8'h22, 4, 1'b0, 1'b0);

    // Strobe on ch3 coincident with ack while the mask holds only ch0.
    repeat (2) cycle(8'h00, 4, 1'b0, 1'b1);
    repeat (12) cycle(8'h01, 4, 1'b0, 1'b0);
    repeat (15) cycle(8'h09, 4, m_rise[3], 1'b0);

    // Wait value changed mid-settle on ch4.
    repeat (2) cycle(8'h00, 5, 1'b0, 1'b1);
    repeat (4) cycle(8'h10, 5, 1'b0, 1'b0);
    repeat (20) cycle(8'h10, 20, 1'b0, 1'b0);
    repeat (30) cycle(8'h00, 20, 1'b0, 1'b0);

    // Maximum wait never wraps; reset abandons the count with no strobe.
    repeat (300) cycle(8'h80, (1 << LGWAIT) - 1, 1'b0, 1'b0);
    cycle(8'h80, 2, 1'b0, 1'b1);
    repeat (10) cycle(8'h00, 2, 1'b0, 1'b0);

    // Long press on ch0 and release.
    repeat (30) cycle(8'h01, 2, 1'b0, 1'b0);
    repeat (10) cycle(8'h00, 2, 1'b1, 1'b0);

    // Randomised traffic.
    w_cur = 3;
    rate  = 20;
    in_v  = '0;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 64) == 0) rate = ($urandom_range(0, 3) == 0) ? 3 : 20;
      if ($urandom_range(0, 63) == 0) w_cur = $urandom_range(0, 12);
      for (int b = 0; b < NIN; b++) begin
        if ($urandom_range(0, rate - 1) == 0) in_v[b] = ~in_v[b];
      end
      cycle(in_v, w_cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 999) == 0));
    end

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d expected=0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule : tb_debounce_bank
